// File: rtl/bit_serial_fa_sequencer.sv
// rtl/bit_serial_fa_sequencer.sv - LSB-first sequencer driving a latency-FA_LAT 1-bit full adder
// Feeds operand bits one per FA_LAT cycles and routes the adder's cout back as the next carry-in.
module bit_serial_fa_sequencer #(
  parameter int W      = 8,
  parameter int FA_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout,
  output logic         fa_a,
  output logic         fa_b,
  output logic         fa_c,
  input  logic         fa_s,
  input  logic         fa_cout,
  output logic         busy
);

  localparam int CW = $clog2(FA_LAT + 1);
  localparam int KW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LP_CNT_RELOAD = CW'(FA_LAT);
  localparam logic [KW-1:0] LP_K_LAST     = KW'(W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic [W-1:0]  r_sum;
  logic [KW-1:0] r_k;
  logic [CW-1:0] r_cnt;
  logic          w_accept;
  logic          w_sample;
  logic          w_last;
  logic          w_release;
  logic [W-1:0]  w_sum_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    busy         = 1'b0;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    w_release    = 1'b0;
    w_last       = (r_k == LP_K_LAST);
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid) w_state_next = ST_RUN;
      end
      ST_RUN: begin
        busy     = 1'b1;
        w_sample = (r_cnt == CW'(1));
        if (w_sample && w_last) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        w_release = out_ready;
        if (out_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // New sum bit enters at the MSB so bit 0 lands at the LSB after W samples.
  assign w_sum_shift = (r_sum >> 1) | (W'(fa_s) << (W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sum     <= '0;
      r_k       <= '0;
      r_cnt     <= '0;
      fa_a      <= 1'b0;
      fa_b      <= 1'b0;
      fa_c      <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      out_valid <= 1'b0;
    end else if (w_accept) begin
      // Bit 0 goes straight to the adder; the remaining bits wait in r_a/r_b.
      r_a   <= in_a >> 1;
      r_b   <= in_b >> 1;
      r_sum <= '0;
      r_k   <= '0;
      r_cnt <= LP_CNT_RELOAD;
      fa_a  <= in_a[0];
      fa_b  <= in_b[0];
      fa_c  <= in_cin;
    end else if (r_state == ST_RUN) begin
      if (w_sample) begin
        r_sum <= w_sum_shift;
        if (w_last) begin
          out_sum   <= w_sum_shift;
          out_cout  <= fa_cout;
          out_valid <= 1'b1;
          fa_a      <= 1'b0;
          fa_b      <= 1'b0;
          fa_c      <= 1'b0;
        end else begin
          fa_a  <= r_a[0];
          fa_b  <= r_b[0];
          fa_c  <= fa_cout;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_k   <= r_k + KW'(1);
          r_cnt <= LP_CNT_RELOAD;
        end
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end else if (w_release) begin
      out_valid <= 1'b0;
    end
  end

endmodule
